// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if: control and status bundle of the PC stage.
//   Requests (core -> sequencer): stall, halt, branch_taken, branch_target,
//     jump, jump_target.
//   Status (sequencer -> core): pc, pc_plus4, pc_valid, redirect, halted,
//     retired, and misalign when PC_ALIGN_CHECK_EN is defined.
//   master: the core-side requester. slave: the pc_sequencer itself.
interface pc_sequencer_if;
  logic        stall;
  logic        halt;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        jump;
  logic [31:0] jump_target;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        pc_valid;
  logic        redirect;
  logic        halted;
  logic [31:0] retired;
`ifdef PC_ALIGN_CHECK_EN
  logic        misalign;
`endif

  modport master (
    output stall, halt, branch_taken, branch_target, jump, jump_target,
    input  pc, pc_plus4, pc_valid, redirect, halted, retired
`ifdef PC_ALIGN_CHECK_EN
    , input misalign
`endif
  );

  modport slave (
    input  stall, halt, branch_taken, branch_target, jump, jump_target,
    output pc, pc_plus4, pc_valid, redirect, halted, retired
`ifdef PC_ALIGN_CHECK_EN
    , output misalign
`endif
  );
endinterface

// File: rtl/pc_sequencer.sv
// pc_sequencer: program-counter stage. Holds the architectural PC, picks the
// next fetch address (jump > branch > pc+4), sequences BOOT/RUN/HALT and
// counts retired (PC-advancing) cycles.
// Ports:
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low reset
//   bus   - pc_sequencer_if.slave (requests in, pc/status out)
// Parameters: RESET_PC (PC after reset), TRAP_PC (misaligned-redirect vector).
// Build option: define PC_ALIGN_CHECK_EN to trap misaligned redirect targets
// to TRAP_PC and expose bus.misalign; otherwise target bits [1:0] are cleared.
module pc_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] TRAP_PC  = 32'h0000_0080
) (
  input  logic          clk,
  input  logic          rst_n,
  pc_sequencer_if.slave bus
);

  typedef enum logic [1:0] {BOOT = 2'd0, RUN = 2'd1, HALT = 2'd2} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q;
  logic [31:0] retired_q;
  logic        redirect_q;
  logic        pc_valid_c, halted_c;
  logic        redir_sel, advance;
  logic [31:0] tgt;

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= BOOT;
    else        state_q <= state_d;
  end

  // next state: HALT is left only through reset
  always_comb begin
    state_d = state_q;
    case (state_q)
      BOOT:    state_d = RUN;
      RUN:     if (bus.halt) state_d = HALT;
      HALT:    state_d = HALT;
      default: state_d = BOOT;
    endcase
  end

  // state-decoded outputs; registered by virtue of coming from state_q
  always_comb begin
    pc_valid_c = 1'b0;
    halted_c   = 1'b0;
    case (state_q)
      RUN:     pc_valid_c = 1'b1;
      HALT:    halted_c   = 1'b1;
      default: ;
    endcase
  end

  // A stalled redirect is dropped, not remembered: the requester re-presents it.
  always_comb begin
    advance   = (state_q == RUN) && !bus.halt && !bus.stall;
    redir_sel = bus.jump | bus.branch_taken;
    tgt       = bus.jump ? bus.jump_target : bus.branch_target;
  end

`ifdef PC_ALIGN_CHECK_EN
  logic misalign_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q       <= RESET_PC;
      retired_q  <= '0;
      redirect_q <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      redirect_q <= 1'b0;
      misalign_q <= 1'b0;
      if (advance) begin
        if (redir_sel) begin
          redirect_q <= 1'b1;
          // a trapped redirect does not retire
          if (|tgt[1:0]) begin
            pc_q       <= TRAP_PC;
            misalign_q <= 1'b1;
          end else begin
            pc_q      <= tgt;
            retired_q <= retired_q + 32'd1;
          end
        end else begin
          pc_q      <= pc_q + 32'd4;
          retired_q <= retired_q + 32'd1;
        end
      end
    end
  end

  assign bus.misalign = misalign_q;
`else
  // TRAP_PC only matters with the alignment trap compiled in
  logic unused_trap_pc;
  assign unused_trap_pc = ^TRAP_PC;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q       <= RESET_PC;
      retired_q  <= '0;
      redirect_q <= 1'b0;
    end else begin
      redirect_q <= 1'b0;
      if (advance) begin
        retired_q <= retired_q + 32'd1;
        if (redir_sel) begin
          redirect_q <= 1'b1;
          pc_q       <= {tgt[31:2], 2'b00};
        end else begin
          pc_q <= pc_q + 32'd4;
        end
      end
    end
  end
`endif

  assign bus.pc       = pc_q;
  assign bus.pc_plus4 = pc_q + 32'd4;
  assign bus.pc_valid = pc_valid_c;
  assign bus.halted   = halted_c;
  assign bus.redirect = redirect_q;
  assign bus.retired  = retired_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed scenarios plus randomized traffic against a
// behavioural model of the PC stage.
module tb_pc_sequencer;
  localparam logic [31:0] RST_PC  = 32'h0000_0000;
  localparam logic [31:0] TRAP_PC = 32'h0000_0080;
`ifdef PC_ALIGN_CHECK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pc_sequencer_if bus();

  pc_sequencer #(.RESET_PC(RST_PC), .TRAP_PC(TRAP_PC)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  int checks = 0;
  int failures = 0;

  // model: mode 0 = booting, 1 = running, 2 = halted
  int          m_mode;
  logic [31:0] m_pc, m_ret;
  bit          m_redir, m_mis;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic m_reset();
    m_mode = 0; m_pc = RST_PC; m_ret = 0; m_redir = 0; m_mis = 0;
  endtask

  task automatic m_edge();
    logic [31:0] t;
    m_redir = 0; m_mis = 0;
    if (m_mode == 0) m_mode = 1;
    else if (m_mode == 1) begin
      if (bus.halt) m_mode = 2;
      else if (bus.stall) ;
      else if (bus.jump || bus.branch_taken) begin
        t = bus.jump ? bus.jump_target : bus.branch_target;
        m_redir = 1;
        if (ALIGN && t % 4 != 0) begin
          m_pc = TRAP_PC; m_mis = 1;
        end else begin
          m_pc = t - (t % 4);
          m_ret = m_ret + 1;
        end
      end else begin
        m_pc = m_pc + 4;
        m_ret = m_ret + 1;
      end
    end
  endtask

  task automatic cmp_all();
    chk("pc", bus.pc, m_pc);
    chk("pc_plus4", bus.pc_plus4, m_pc + 32'd4);
    chk("pc_valid", {31'b0, bus.pc_valid}, (m_mode == 1) ? 32'd1 : 32'd0);
    chk("halted", {31'b0, bus.halted}, (m_mode == 2) ? 32'd1 : 32'd0);
    chk("redirect", {31'b0, bus.redirect}, {31'b0, m_redir});
    chk("retired", bus.retired, m_ret);
`ifdef PC_ALIGN_CHECK_EN
    chk("misalign", {31'b0, bus.misalign}, {31'b0, m_mis});
`endif
  endtask

  // drive at negedge, clock once, step the model, compare at the next negedge
  task automatic cyc(input bit st, input bit hl, input bit br, input logic [31:0] bt,
                     input bit jp, input logic [31:0] jt);
    bus.stall = st; bus.halt = hl; bus.branch_taken = br; bus.branch_target = bt;
    bus.jump = jp; bus.jump_target = jt;
    @(posedge clk);
    if (rst_n) m_edge();
    @(negedge clk);
    cmp_all();
  endtask

  task automatic idle();
    cyc(0, 0, 0, 32'h0, 0, 32'h0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    m_reset();
    cmp_all();
    idle();
    rst_n = 1'b1;
  endtask

  initial begin
    logic [31:0] r0, bt, jt;
    bit st, hl, br, jp;
    m_reset();
    bus.stall = 0; bus.halt = 0; bus.branch_taken = 0; bus.branch_target = 0;
    bus.jump = 0; bus.jump_target = 0;
    @(negedge clk);

    // reset held three cycles, values checked against constants
    for (int i = 0; i < 3; i++) idle();
    chk("rst_pc", bus.pc, 32'h0);
    chk("rst_valid", {31'b0, bus.pc_valid}, 32'd0);
    chk("rst_retired", bus.retired, 32'd0);
    rst_n = 1'b1;

    // boot then sequential fetch
    idle();
    chk("boot_pc", bus.pc, 32'h0);
    chk("boot_valid", {31'b0, bus.pc_valid}, 32'd1);
    idle(); chk("seq_pc4", bus.pc, 32'h4);
    idle(); chk("seq_pc8", bus.pc, 32'h8);
    idle(); chk("seq_pc12", bus.pc, 32'hC);
    chk("seq_retired", bus.retired, 32'd3);
    idle(); chk("seq_pc16", bus.pc, 32'h10);

    // jump beats branch
    cyc(0, 0, 1, 32'h40, 1, 32'h200);
    chk("prio_pc", bus.pc, 32'h200);
    chk("prio_redir", {31'b0, bus.redirect}, 32'd1);
    idle();
    chk("prio_redir_clr", {31'b0, bus.redirect}, 32'd0);
    chk("prio_next", bus.pc, 32'h204);

    // stall drops a branch
    cyc(0, 0, 0, 32'h0, 1, 32'h20);
    r0 = bus.retired;
    cyc(1, 0, 1, 32'h80, 0, 32'h0);
    chk("stall_pc1", bus.pc, 32'h20);
    cyc(1, 0, 1, 32'h80, 0, 32'h0);
    chk("stall_pc2", bus.pc, 32'h20);
    chk("stall_retired", bus.retired, r0);
    idle();
    chk("stall_after", bus.pc, 32'h24);

    // wrap then halt
    cyc(0, 0, 0, 32'h0, 1, 32'hFFFF_FFFC);
    chk("wrap_p4", bus.pc_plus4, 32'h0);
    idle(); chk("wrap_pc", bus.pc, 32'h0);
    cyc(0, 1, 0, 32'h0, 1, 32'h300);
    chk("halt_flag", {31'b0, bus.halted}, 32'd1);
    chk("halt_pc", bus.pc, 32'h0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 1, 32'h500, 1, 32'h600);
    chk("halt_frozen", bus.pc, 32'h0);

    // misaligned jump
    do_reset();
    idle();
    cyc(0, 0, 0, 32'h0, 1, 32'h102);
    chk("align_pc", bus.pc, ALIGN ? TRAP_PC : 32'h100);
    idle();

    // async reset between edges
    do_reset();
    idle();
    cyc(0, 0, 0, 32'h0, 1, 32'h44);
    chk("async_pre", bus.pc, 32'h44);
    #2 rst_n = 1'b0;
    #1;
    chk("async_pc", bus.pc, 32'h0);
    chk("async_retired", bus.retired, 32'h0);
    m_reset();
    cmp_all();
    @(negedge clk);
    rst_n = 1'b1;

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 99) < 2) begin
        #($urandom_range(1, 3));
        rst_n = 1'b0;
        #1;
        m_reset();
        cmp_all();
        @(negedge clk);
        idle();
        rst_n = 1'b1;
      end else begin
        st = ($urandom_range(0, 3) == 0);
        hl = ($urandom_range(0, 79) == 0);
        br = ($urandom_range(0, 9) < 3);
        jp = ($urandom_range(0, 9) < 2);
        bt = $urandom;
        jt = $urandom;
        if ($urandom_range(0, 3) != 0) bt[1:0] = 2'b00;
        if ($urandom_range(0, 3) != 0) jt[1:0] = 2'b00;
        cyc(st, hl, br, bt, jp, jt);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Program-counter stage of the single-cycle CPU. Holds the architectural PC and selects the next fetch address from sequential PC+4, the branch target produced by the immediate adder (`pc + imm`), or an absolute jump target. It also sequences boot, stall, and halt, and counts retired instructions. It sits directly upstream of instruction fetch and both feeds and consumes the immediate adder: it drives `pc` into the adder and takes the sum back as `branch_target`.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC loaded on reset.
- `TRAP_PC`, default 32'h0000_0080: PC loaded on a misaligned redirect; used only when the alignment check is compiled in.
- `clk`  input  1  rising-edge clock.
- `rst_n`  input  1  asynchronous, active-low reset.
- `stall`  input  1  hold PC this cycle.
- `halt`  input  1  enter HALT; sampled in RUN only.
- `branch_taken`  input  1  redirect to `branch_target`.
- `branch_target`  input  32  `pc + imm` from the immediate adder.
- `jump`  input  1  redirect to `jump_target`.
- `jump_target`  input  32  absolute jump address.
- `pc`  output  32  current fetch address (registered).
- `pc_plus4`  output  32  `pc + 4`, combinational, mod 2^32.
- `pc_valid`  output  1  high in RUN; `pc` is a real fetch.
- `redirect`  output  1  registered pulse, high for the cycle after a taken jump or branch.
- `halted`  output  1  high in HALT.
- `retired`  output  32  count of RUN cycles that advance PC.
- `misalign`  output  1  registered pulse on an alignment trap; compiled in only with the macro.

## Operation
- FSM states: BOOT, RUN, HALT. Reset state is BOOT.
- BOOT → RUN unconditionally after one cycle. PC holds `RESET_PC`.
- RUN → HALT when `halt`=1. `halt` wins over all other inputs.
- HALT is terminal. The only exit is `rst_n`.
- Next-PC priority in RUN: `halt` > `stall` > `jump` > `branch_taken` > sequential.
  - `halt` or `stall`: PC holds.
  - `jump`: PC ← `jump_target`.
  - `branch_taken`: PC ← `branch_target`.
  - Otherwise: PC ← `pc_plus4`.
- Simultaneous `jump` and `branch_taken`: the jump wins and the branch is dropped.
- `stall` together with `jump` or `branch_taken`: the redirect is dropped, not deferred. The requester holds its request until `stall` drops.
- `redirect` sets to 1 on any edge that loads a jump or branch target, and is 0 otherwise.
- `retired` increments on every RUN edge where PC advances, i.e. when none of `stall`, `halt`, or the trap applies. It wraps from 32'hFFFF_FFFF to 0 and is never saturated.
- Arithmetic: all PC math is unsigned 32-bit and wraps. 32'hFFFF_FFFC + 4 = 0.
- Inputs are ignored in BOOT and in HALT.

## Timing
- Reset values (async, immediate on `rst_n`=0):
  - `pc` = `RESET_PC`, `pc_valid` = 0, `redirect` = 0, `halted` = 0, `retired` = 0, `misalign` = 0, state = BOOT.
- Reset asserted mid-operation aborts the current cycle. No partial update survives.
- Reset is released asynchronously. Inputs must be stable before the first rising edge after release.
- First edge after release: BOOT → RUN and `pc_valid` = 1, with `pc` still `RESET_PC`.
- Redirect latency is one edge: a target presented in cycle N appears on `pc` in cycle N+1.
- `pc_plus4` has zero latency from `pc`.
- `halted` rises on the edge that samples `halt`. From that edge `pc_valid` = 0 and `pc` is frozen at its value before that edge.

## Configuration
- Macro: `PC_ALIGN_CHECK_EN`.
- Defined:
  - A selected redirect target with bits [1:0] ≠ 0 loads `TRAP_PC` instead of the target.
  - `misalign` pulses for one cycle and `redirect` = 1.
  - `retired` does not increment on that edge.
- Undefined:
  - Target bits [1:0] are forced to 2'b00 on load.
  - The `misalign` port is absent and `TRAP_PC` is unused.

## Test plan
- Reset and boot: `rst_n` low 3 cycles, then high, no inputs. `pc` = 0 at the first edge; then 4, 8, 12 on the following edges. `pc_valid` rises at the first edge. `retired` = 3 after four edges.
- Branch vs jump priority: at `pc`=0x10, assert `branch_taken` (`branch_target`=0x40) and `jump` (`jump_target`=0x200) together. Next `pc` = 0x200 and `redirect` = 1 for one cycle.
- Stall drops redirect: at `pc`=0x20, assert `stall`=1 and `branch_taken`=1 (target 0x80) for 2 cycles, then drop both. `pc` stays 0x20 for two cycles, then 0x24. `retired` is unchanged during the stall.
- Wrap and halt: force `pc`=0xFFFF_FFFC via a jump. Next `pc` = 0x0. Then assert `halt` together with `jump`: `halted` = 1, `pc` frozen at 0x0, and later inputs are ignored until reset.
- Alignment, macro defined: jump to 0x102. `pc` = `TRAP_PC` (0x80), `misalign` pulses once.
- Alignment, macro undefined: jump to 0x102. `pc` = 0x100.
- Async reset mid-run: drop `rst_n` between edges while `pc`=0x44. `pc` returns to 0 and `retired` to 0 immediately, without waiting for a clock edge.
